// File: rtl/upsample_stream_driver.sv
// Host-side DMA driver for the upsample engine: streams each channel of a layer out, writes results back.
// Optional perf counters (perf_tx_stall, perf_rx_wait) are enabled by `define UPSAMPLE_DRIVER_PERF_EN.
module upsample_stream_driver #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SRC_AW     = 20,
    parameter int unsigned DST_AW     = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            cfg_size,
    input  logic [8:0]            cfg_channels,
    output logic                  busy,
    output logic                  done,
    output logic                  tlast_err,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  src_en,
    output logic [SRC_AW-1:0]     src_addr,
    input  logic [DATA_WIDTH-1:0] src_rdata,
    output logic                  dst_we,
    output logic [DST_AW-1:0]     dst_addr,
    output logic [DATA_WIDTH-1:0] dst_wdata
`ifdef UPSAMPLE_DRIVER_PERF_EN
    ,
    output logic [31:0]           perf_tx_stall,
    output logic [31:0]           perf_rx_wait
`endif
);

    typedef enum logic [1:0] {StIdle, StTx, StRx, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            size_q;
    logic [8:0]            chans_q;
    logic [8:0]            ch_q;
    logic [12:0]           rd_cnt_q;
    logic [14:0]           rx_cnt_q;
    logic [SRC_AW-1:0]     src_ptr_q;
    logic [DST_AW-1:0]     dst_ptr_q;
    logic                  rd_pend_q;
    logic                  rd_pend_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  fifo_wr_q;
    logic                  fifo_rd_q;
    logic [1:0]            fifo_cnt_q;
    logic                  dst_we_q;
    logic [DST_AW-1:0]     dst_addr_q;
    logic [DATA_WIDTH-1:0] dst_wdata_q;
    logic                  tlast_err_q;

    logic        start_acc;
    logic [12:0] n_in;
    logic [14:0] n_out;
    logic        tx_fire;
    logic        rx_fire;
    logic        rx_last;
    logic [2:0]  level;

    assign start_acc = (state_q == StIdle) && start;
    assign n_in      = 13'd16 << {size_q, 1'b0};
    assign n_out     = {n_in, 2'b00};

    assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign m_axis_tdata  = fifo_data_q[fifo_rd_q];
    assign m_axis_tlast  = m_axis_tvalid && fifo_last_q[fifo_rd_q];
    assign tx_fire       = m_axis_tvalid && m_axis_tready;

    // Count the beat leaving this cycle so a full pipe still issues a read each cycle at tready=1.
    assign level  = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, tx_fire};
    assign src_en = (state_q == StTx) && (rd_cnt_q != n_in) && (level < 3'd2);
    assign src_addr = src_ptr_q;

    assign s_axis_tready = (state_q == StRx);
    assign rx_fire       = s_axis_tready && s_axis_tvalid;
    assign rx_last       = (rx_cnt_q == n_out - 15'd1);

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign tlast_err = tlast_err_q;
    assign dst_we    = dst_we_q;
    assign dst_addr  = dst_addr_q;
    assign dst_wdata = dst_wdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = (cfg_channels == 9'd0) ? StDone : StTx;
            StTx:   if (tx_fire && m_axis_tlast) state_d = StRx;
            StRx: begin
                if (rx_fire && rx_last) begin
                    state_d = (ch_q + 9'd1 == chans_q) ? StDone : StTx;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            size_q         <= 3'd0;
            chans_q        <= 9'd0;
            ch_q           <= 9'd0;
            rd_cnt_q       <= 13'd0;
            rx_cnt_q       <= 15'd0;
            src_ptr_q      <= '0;
            dst_ptr_q      <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
            fifo_last_q    <= 2'b00;
            fifo_wr_q      <= 1'b0;
            fifo_rd_q      <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            dst_we_q       <= 1'b0;
            dst_addr_q     <= '0;
            dst_wdata_q    <= '0;
            tlast_err_q    <= 1'b0;
        end else begin
            dst_we_q <= 1'b0;
            if (start_acc) begin
                size_q      <= (cfg_size > 3'd4) ? 3'd0 : cfg_size;
                chans_q     <= cfg_channels;
                ch_q        <= 9'd0;
                rd_cnt_q    <= 13'd0;
                rx_cnt_q    <= 15'd0;
                src_ptr_q   <= '0;
                dst_ptr_q   <= '0;
                tlast_err_q <= 1'b0;
            end
            if (src_en) begin
                src_ptr_q <= src_ptr_q + SRC_AW'(1);
                rd_cnt_q  <= rd_cnt_q + 13'd1;
            end
            rd_pend_q      <= src_en;
            rd_pend_last_q <= src_en && (rd_cnt_q == n_in - 13'd1);
            if (rd_pend_q) begin
                fifo_data_q[fifo_wr_q] <= src_rdata;
                fifo_last_q[fifo_wr_q] <= rd_pend_last_q;
                fifo_wr_q              <= ~fifo_wr_q;
            end
            if (tx_fire) fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, tx_fire};
            if (state_q == StRx && state_d == StTx) begin
                ch_q     <= ch_q + 9'd1;
                rd_cnt_q <= 13'd0;
            end
            // Frames end by beat count; tlast is only cross-checked.
            if (rx_fire) begin
                dst_we_q    <= 1'b1;
                dst_addr_q  <= dst_ptr_q;
                dst_wdata_q <= s_axis_tdata;
                dst_ptr_q   <= dst_ptr_q + DST_AW'(1);
                rx_cnt_q    <= rx_last ? 15'd0 : rx_cnt_q + 15'd1;
                if (s_axis_tlast != rx_last) tlast_err_q <= 1'b1;
            end
        end
    end

`ifdef UPSAMPLE_DRIVER_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] wait_q;

    always_ff @(posedge clk) begin
        if (!reset || start_acc) begin
            stall_q <= 32'd0;
            wait_q  <= 32'd0;
        end else begin
            if (m_axis_tvalid && !m_axis_tready && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (state_q == StRx && !s_axis_tvalid && wait_q != 32'hFFFF_FFFF) begin
                wait_q <= wait_q + 32'd1;
            end
        end
    end

    assign perf_tx_stall = stall_q;
    assign perf_rx_wait  = wait_q;
`endif

endmodule
